// File: rtl/mmio_timer.sv
`timescale 1ns/1ps
// mmio_timer: memory-mapped, prescaled 32-bit down-counter that answers the
// CPU data-memory port next to the data RAM. Read data and irq are registered
// so the MEM->WB path sees the same one-cycle latency as the RAM.
module mmio_timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [5:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    // Word offsets of the registers; offsets 5..7 are unmapped.
    typedef enum logic [2:0] {
        RegCtrl   = 3'd0,
        RegLoad   = 3'd1,
        RegCount  = 3'd2,
        RegStatus = 3'd3,
        RegPresc  = 3'd4
    } regIdx_t;

    logic                  ctrlEn;
    logic                  ctrlReload;
    logic                  ctrlIe;
    logic [31:0]           loadVal;
    logic [31:0]           countVal;
    logic                  expFlag;
    logic [PRESCALE_W-1:0] prescVal;
    logic [PRESCALE_W-1:0] pc;

    logic [2:0]            regIdx;
    logic [2:0]            unusedAddrHigh;
    logic                  wrAccess;
    logic                  wrCtrl;
    logic                  wrLoad;
    logic                  wrCount;
    logic                  wrStatus;
    logic                  wrPresc;
    logic                  enRise;
    logic                  tick;
    logic                  expire;
    logic [31:0]           readData;

    // Only the low three word-address bits select a register; the rest alias.
    assign regIdx         = addr[2:0];
    assign unusedAddrHigh = addr[5:3];

    assign wrAccess = sel & we;
    assign wrCtrl   = wrAccess && (regIdx == RegCtrl);
    assign wrLoad   = wrAccess && (regIdx == RegLoad);
    assign wrCount  = wrAccess && (regIdx == RegCount);
    assign wrStatus = wrAccess && (regIdx == RegStatus);
    assign wrPresc  = wrAccess && (regIdx == RegPresc);

    // A CTRL write turning EN on restarts the prescaler so the first tick is P+1 cycles out.
    assign enRise = wrCtrl & din[0] & ~ctrlEn;
    assign tick   = ctrlEn && (pc == prescVal);
    assign expire = tick && (countVal == 32'd0);

    // Prescaler: counts 0..P while enabled, wrapping to 0 on each tick.
    always_ff @(posedge clk) begin
        // NOTE: reset is tested first so it overrides any same-cycle write or tick.
        if (reset) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            pc <= '0;
        end else if (enRise || tick) begin
            pc <= '0;
        end else if (ctrlEn) begin
            pc <= pc + PRESCALE_W'(1);
        end
    end

    // Control bits: a CPU write beats the one-shot EN clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrlEn     <= 1'b0;
            ctrlReload <= 1'b0;
            ctrlIe     <= 1'b0;
        end else if (wrCtrl) begin
            ctrlEn     <= din[0];
            ctrlReload <= din[1];
            ctrlIe     <= din[2];
        end else if (expire && !ctrlReload) begin
            ctrlEn <= 1'b0;
        end
    end

    // Reload value and prescaler divider are plain CPU-written registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            loadVal  <= '0;
            prescVal <= '0;
        end else begin
            if (wrLoad)  loadVal  <= din;
            if (wrPresc) prescVal <= din[PRESCALE_W-1:0];
        end
    end

    // Down-counter: CPU write wins over a tick; zero either reloads (old LOAD) or holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            countVal <= '0;
        end else if (wrCount) begin
            countVal <= din;
        end else if (tick) begin
            if (countVal != 32'd0) begin
                countVal <= countVal - 32'd1;
            end else if (ctrlReload) begin
                countVal <= loadVal;
            end
        end
    end

    // Sticky expiry flag: a new expiry beats a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            expFlag <= 1'b0;
        end else if (expire) begin
            expFlag <= 1'b1;
        end else if (wrStatus && din[0]) begin
            expFlag <= 1'b0;
        end
    end

    // Read mux: selects the addressed register; unmapped offsets read as zero.
    always_comb begin
        // NOTE: defaulting readData first keeps this block free of inferred latches.
        readData = '0;
        case (regIdx)
            RegCtrl:   readData = {29'd0, ctrlIe, ctrlReload, ctrlEn};
            RegLoad:   readData = loadVal;
            RegCount:  readData = countVal;
            RegStatus: readData = {31'd0, expFlag};
            RegPresc:  readData = 32'(prescVal);
            default:   readData = '0;
        endcase
    end

    // Registered outputs: read data every cycle regardless of sel, and the level interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
            irq  <= 1'b0;
        end else begin
            dout <= readData;
            irq  <= expFlag & ctrlIe;
        end
    end

endmodule
